sprite_rom_sequencer: RTL

- Drives the address and frame select for the scaled sprite ROM/palette pipeline.
- Replaces the per-pixel multiply/divide address computation with incremental row/column accumulators.
- Sequences animation frames (frame_sel picks which sprite ROM feeds the palette) at frame boundaries only.
- Delays the active-video flag to line up with ROM read latency.
- Sits between the VGA timing controller (DrawX/DrawY/blank) and the sprite ROM mux.

---
 rtl/sprite_rom_sequencer.sv | 112 +++++++++++
 1 files changed

// File: rtl/sprite_rom_sequencer.sv
// sprite_rom_sequencer: incremental scaled sprite ROM addressing, animation frame select and video-valid delay
module sprite_rom_sequencer #(
  parameter int IMG_W       = 53,
  parameter int IMG_H       = 40,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int ADDR_W      = 12,
  parameter int NUM_FRAMES  = 2,
  parameter int FRAME_HOLD  = 8,
  parameter int ROM_LATENCY = 1,
  localparam int FS_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              anim_en,
  input  logic              anim_restart,
  output logic [ADDR_W-1:0] rom_address,
  output logic [FS_W-1:0]   frame_sel,
  output logic              pix_valid,
  output logic              frame_tick
);
  localparam int AXW = $clog2(H_ACTIVE + IMG_W + 1);
  localparam int AYW = $clog2(V_ACTIVE + IMG_H + 1);
  localparam int HW  = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam logic [9:0]        X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0]        Y_LAST = 10'(V_ACTIVE - 1);
  localparam logic [AXW-1:0]    HA     = AXW'(H_ACTIVE);
  localparam logic [AXW-1:0]    IW     = AXW'(IMG_W);
  localparam logic [AYW-1:0]    VA     = AYW'(V_ACTIVE);
  localparam logic [AYW-1:0]    IH     = AYW'(IMG_H);
  localparam logic [ADDR_W-1:0] ROW_W  = ADDR_W'(IMG_W);
  localparam logic [HW-1:0]     H_LAST = HW'(FRAME_HOLD - 1);
  localparam logic [FS_W-1:0]   F_LAST = FS_W'(NUM_FRAMES - 1);

  logic [AXW-1:0]         accx, accx_e, accx_n;
  logic [AYW-1:0]         accy, accy_e, accy_n;
  logic [ADDR_W-1:0]      col, col_e, row_base, row_e;
  logic [HW-1:0]          hold;
  logic [ROM_LATENCY-1:0] vsr;
  logic                   line_end, frame_org, frame_end;

  // effective state: a line start zeroes the column, a frame origin zeroes the row, so stale state never leaks into an address
  always_comb begin
    line_end    = blank && DrawX == X_LAST;
    frame_org   = DrawX == 10'd0 && DrawY == 10'd0;
    frame_end   = line_end && DrawY == Y_LAST;
    col_e       = (DrawX == 10'd0) ? '0 : col;
    accx_e      = (DrawX == 10'd0) ? '0 : accx;
    row_e       = frame_org ? '0 : row_base;
    accy_e      = frame_org ? '0 : accy;
    accx_n      = accx_e + IW;
    accy_n      = accy_e + IH;
    rom_address = col_e + row_e;
  end

  // column accumulator: one texel step per active pixel, remainder carried in accx
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      col  <= '0;
      accx <= '0;
    end else if (line_end) begin
      col  <= '0;
      accx <= '0;
    end else if (blank) begin
      col  <= (accx_n >= HA) ? col_e + ADDR_W'(1) : col_e;
      accx <= (accx_n >= HA) ? accx_n - HA : accx_n;
    end
  end

  // row accumulator: advanced once per line, cleared at the last line and at every frame origin
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      row_base <= '0;
      accy     <= '0;
    end else if (frame_end || (frame_org && !line_end)) begin
      row_base <= '0;
      accy     <= '0;
    end else if (line_end) begin
      row_base <= (accy_n >= VA) ? row_e + ROW_W : row_e;
      accy     <= (accy_n >= VA) ? accy_n - VA : accy_n;
    end
  end

  // active-video flag delayed to match the ROM read latency
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) vsr <= '0;
    else vsr <= (vsr << 1) | ROM_LATENCY'(blank);
  end

  assign pix_valid = vsr[ROM_LATENCY-1];

  // end-of-frame pulse and animation sequencing; frame_sel only moves at frame end or restart
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_tick <= 1'b0;
      hold       <= '0;
      frame_sel  <= '0;
    end else begin
      frame_tick <= frame_end;
      if (anim_restart) begin
        hold      <= '0;
        frame_sel <= '0;
      end else if (frame_end && anim_en) begin
        hold      <= (hold == H_LAST) ? '0 : hold + HW'(1);
        frame_sel <= (hold != H_LAST) ? frame_sel : (frame_sel == F_LAST) ? '0 : frame_sel + FS_W'(1);
      end
    end
  end
endmodule
